// File: rtl/cenc_framer_213.sv
// Framed (2,1,3) convolutional encoder: N data symbols plus M zero-tail symbols per frame.
// Build macro CENC_ERR_INJECT_EN adds err_mask/err_idx symbol error injection.
module cenc_framer_213 #(
    parameter int unsigned N  = 256,
    parameter int unsigned M  = 3,
    parameter logic [M:0]  G0 = 4'b1111,
    parameter logic [M:0]  G1 = 4'b1101
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] sym_out,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       seq_ready,
    output logic       busy,
    output logic       frame_done
`ifdef CENC_ERR_INJECT_EN
    ,
    input  logic [1:0] err_mask,
    input  logic [8:0] err_idx
`endif
);

    localparam int unsigned TW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {StIdle, StData, StTail, StFlush} state_e;

    state_e          state_q, state_d;
    logic [M-1:0]    sr_q;
    logic [8:0]      bit_cnt_q;
    logic [TW-1:0]   tail_cnt_q;
    logic [1:0]      sym_q;
    logic            sym_valid_q;
    logic            seq_ready_q;

    logic            slot_free;
    logic            accept;
    logic            tail_gen;
    logic            produce;
    logic            start_hs;
    logic [M:0]      w;
    logic [1:0]      code;
    logic [1:0]      code_out;

    // Output register is free when empty or being drained this cycle.
    assign slot_free = !sym_valid_q || sym_ready;
    assign accept    = din_valid && din_ready;
    assign tail_gen  = (state_q == StTail) && slot_free;
    assign produce   = accept || tail_gen;
    assign start_hs  = (state_q == StIdle) && start;
    assign w         = {accept && din, sr_q};
    assign code      = {^(w & G1), ^(w & G0)};

`ifdef CENC_ERR_INJECT_EN
    logic [9:0] sym_idx_q;
    logic [8:0] err_idx_q;

    assign code_out = (sym_idx_q == {1'b0, err_idx_q}) ? (code ^ err_mask) : code;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sym_idx_q <= '0;
            err_idx_q <= '0;
        end else if (start_hs) begin
            sym_idx_q <= '0;
            err_idx_q <= err_idx;
        end else if (produce) begin
            sym_idx_q <= sym_idx_q + 10'd1;
        end
    end
`else
    assign code_out = code;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StData;
            StData:  if (accept && (bit_cnt_q == 9'(N - 1))) state_d = StTail;
            StTail:  if (tail_gen && (tail_cnt_q == TW'(M - 1))) state_d = StFlush;
            StFlush: if (sym_valid_q && sym_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        din_ready  = (state_q == StData) && slot_free;
        busy       = (state_q != StIdle);
        frame_done = (state_q == StFlush) && sym_valid_q && sym_ready;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            seq_ready_q <= 1'b0;
        end else begin
            seq_ready_q <= start_hs;
            if (start_hs) begin
                sr_q       <= '0;
                bit_cnt_q  <= '0;
                tail_cnt_q <= '0;
            end else if (produce) begin
                sr_q  <= w[M:1];
                sym_q <= code_out;
                if (accept) begin
                    bit_cnt_q <= bit_cnt_q + 9'd1;
                end
                if (tail_gen) begin
                    tail_cnt_q <= tail_cnt_q + TW'(1);
                end
            end
            if (produce) begin
                sym_valid_q <= 1'b1;
            end else if (sym_ready) begin
                sym_valid_q <= 1'b0;
            end
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = sym_valid_q;
    assign seq_ready = seq_ready_q;

endmodule

// File: tb/tb_cenc_framer_213.sv
// Bench for cenc_framer_213: a small N=3 instance driven from a vector table,
// and an N=256 instance run at full throughput against a reference encoder.
module tb_cenc_framer_213;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic       a_start, a_din, a_din_valid, a_din_ready, a_sym_valid, a_sym_ready;
    logic       a_seq_ready, a_busy, a_frame_done;
    logic [1:0] a_sym_out;
    logic       b_start, b_din, b_din_valid, b_din_ready, b_sym_valid, b_sym_ready;
    logic       b_seq_ready, b_busy, b_frame_done;
    logic [1:0] b_sym_out;

    cenc_framer_213 #(.N(3)) u_a (
        .clock(clock), .reset(reset), .start(a_start), .din(a_din),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .sym_out(a_sym_out),
        .sym_valid(a_sym_valid), .sym_ready(a_sym_ready), .seq_ready(a_seq_ready),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    cenc_framer_213 #(.N(256)) u_b (
        .clock(clock), .reset(reset), .start(b_start), .din(b_din),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .sym_out(b_sym_out),
        .sym_valid(b_sym_valid), .sym_ready(b_sym_ready), .seq_ready(b_seq_ready),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    typedef struct {
        logic [2:0]      bits;   // bits[0] is sent first
        bit              stall;
        bit              hold_start;
        logic [5:0][1:0] syms;   // syms[0] is the first symbol out
    } vec_t;

    vec_t       tbl[6];
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic       b_bits[256];
    int         a_seq_cnt = 0, a_done_cnt = 0;
    int         b_sym_cnt = 0, b_done_cnt = 0, b_first = 0, b_last = 0, b_done_cyc = 0;
    int         cyc = 0;
    logic       a_hold = 1'b0;
    logic [1:0] a_hold_val = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: h[0] is the current bit, h[k] the bit k steps earlier.
    function automatic logic [1:0] enc(input logic [3:0] h);
        return {h[0] ^ h[1] ^ h[3], h[0] ^ h[1] ^ h[2] ^ h[3]};
    endfunction

    function automatic vec_t mkvec(input logic [2:0] bits, input bit stall, input bit hold,
                                   input logic [1:0] s0, input logic [1:0] s1,
                                   input logic [1:0] s2, input logic [1:0] s3,
                                   input logic [1:0] s4, input logic [1:0] s5);
        vec_t v;
        v.bits       = bits;
        v.stall      = stall;
        v.hold_start = hold;
        v.syms       = {s5, s4, s3, s2, s1, s0};
        return v;
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                check("a_hold_valid", a_sym_valid, 1);
                check("a_hold_sym", a_sym_out, a_hold_val);
            end
            if (a_sym_valid && !a_sym_ready) check("a_din_ready_stall", a_din_ready, 0);
            a_hold     = a_sym_valid && !a_sym_ready;
            a_hold_val = a_sym_out;
            if (a_sym_valid && a_sym_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra_sym: got %b expected no symbol", a_sym_out);
                end else begin
                    check("a_sym", a_sym_out, qa.pop_front());
                end
            end
            if (a_seq_ready) a_seq_cnt++;
            if (a_frame_done) a_done_cnt++;
        end
    end

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (b_sym_valid && b_sym_ready) begin
                if (b_sym_cnt == 0) b_first = cyc;
                b_last = cyc;
                b_sym_cnt++;
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra_sym: got %b expected no symbol", b_sym_out);
                end else begin
                    check("b_sym", b_sym_out, qb.pop_front());
                end
            end
            if (b_frame_done) begin
                b_done_cnt++;
                b_done_cyc = cyc;
            end
        end
    end

    task automatic run_frame_a(input vec_t v);
        int   idx   = 0;
        int   guard = 0;
        int   seq0  = a_seq_cnt;
        int   done0 = a_done_cnt;
        bit   hs;
        bit   done  = 1'b0;
        for (int s = 0; s < 6; s++) qa.push_back(v.syms[s]);
        a_start = 1'b1;
        @(posedge clock);
        #1;
        check("a_seq_ready_pulse", a_seq_ready, 1);
        check("a_busy_data", a_busy, 1);
        while (!done && guard < 100) begin
            a_start     = v.hold_start;
            a_din       = (idx < 3) ? v.bits[idx] : 1'b0;
            a_din_valid = (idx < 3) && ($urandom_range(0, 3) != 0);
            a_sym_ready = !(v.stall && guard >= 2 && guard < 7);
            @(negedge clock);
            hs   = a_din_valid && a_din_ready;
            done = a_frame_done;
            @(posedge clock);
            #1;
            if (hs) idx++;
            guard++;
        end
        a_start     = 1'b0;
        a_din_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL a_timeout: got no frame_done expected frame_done within 100 cycles");
        end
        check("a_bits_taken", idx, 3);
        check("a_seq_once", a_seq_cnt - seq0, 1);
        check("a_done_once", a_done_cnt - done0, 1);
        check("a_queue_empty", qa.size(), 0);
        check("a_idle_busy", a_busy, 0);
        check("a_idle_seq", a_seq_ready, 0);
        check("a_sr_zero", u_a.sr_q, 0);
    endtask

    task automatic run_b();
        int         idx   = 0;
        int         guard = 0;
        bit         hs;
        logic [3:0] hist  = 4'b0000;
        for (int i = 0; i < 256; i++) b_bits[i] = 1'($urandom_range(0, 1));
        b_sym_ready = 1'b1;
        b_start     = 1'b1;
        @(posedge clock);
        #1;
        b_start = 1'b0;
        check("b_seq_ready_pulse", b_seq_ready, 1);
        while (b_done_cnt == 0 && guard < 400) begin
            b_din_valid = (idx < 256);
            b_din       = (idx < 256) ? b_bits[idx] : 1'b0;
            @(negedge clock);
            hs = b_din_valid && b_din_ready;
            if (hs) begin
                hist = {hist[2:0], b_din};
                qb.push_back(enc(hist));
                if (idx == 255) begin
                    for (int t = 0; t < 3; t++) begin
                        hist = {hist[2:0], 1'b0};
                        qb.push_back(enc(hist));
                    end
                end
            end
            @(posedge clock);
            #1;
            if (hs) idx++;
            guard++;
        end
        b_din_valid = 1'b0;
        if (b_done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL b_timeout: got no frame_done expected frame_done within 400 cycles");
        end
        @(posedge clock);
        #1;
        check("b_sym_count", b_sym_cnt, 259);
        check("b_consecutive", b_last - b_first, 258);
        check("b_done_once", b_done_cnt, 1);
        check("b_done_on_last", b_done_cyc, b_last);
        check("b_queue_empty", qb.size(), 0);
        check("b_idle_busy", b_busy, 0);
    endtask

    initial begin
        a_start = 0; a_din = 0; a_din_valid = 0; a_sym_ready = 1;
        b_start = 0; b_din = 0; b_din_valid = 0; b_sym_ready = 1;
        #2 reset = 1'b0;
        #10;
        check("rst_sym_out", a_sym_out, 0);
        check("rst_sym_valid", a_sym_valid, 0);
        check("rst_din_ready", a_din_ready, 0);
        check("rst_seq_ready", a_seq_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_frame_done", a_frame_done, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        tbl[0] = mkvec(3'b101, 0, 0, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11);
        tbl[1] = mkvec(3'b000, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        tbl[2] = mkvec(3'b111, 0, 1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11);
        tbl[3] = mkvec(3'b001, 1, 0, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00);
        tbl[4] = mkvec(3'b010, 0, 1, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00);
        tbl[5] = mkvec(3'b101, 1, 0, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11);
        for (int v = 0; v < 6; v++) run_frame_a(tbl[v]);

        // Abandon a frame mid-DATA with an asynchronous reset.
        a_start = 1'b1;
        @(posedge clock);
        #1;
        a_start     = 1'b0;
        a_din       = 1'b1;
        a_din_valid = 1'b1;
        @(posedge clock);
        #1;
        check("mid_sym_valid", a_sym_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_sym_out", a_sym_out, 0);
        check("mid_rst_sym_valid", a_sym_valid, 0);
        check("mid_rst_din_ready", a_din_ready, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_frame_done", a_frame_done, 0);
        check("mid_rst_sr", u_a.sr_q, 0);
        a_din_valid = 1'b0;
        qa.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_frame_a(tbl[0]);

        run_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
